// File: rtl/led_bank_arbiter.sv
// Two-port LED bank arbiter with request/grant ownership, a minimum hold time
// and round-robin alternation under contention. All outputs are registered.
module led_bank_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] leds,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             rr_ptr_q;
  logic [WIDTH-1:0] leds_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             busy_q;

  logic             own_req;
  logic             oth_req;
  logic [WIDTH-1:0] own_data;
  logic [WIDTH-1:0] oth_data;
  logic             expired;
  logic             pick1;

  // Owner/competitor view of the ports, so OWN0 and OWN1 share one code path.
  always_comb begin
    own_req  = (state_q == OWN1) ? req1  : req0;
    oth_req  = (state_q == OWN1) ? req0  : req1;
    own_data = (state_q == OWN1) ? data1 : data0;
    oth_data = (state_q == OWN1) ? data0 : data1;
    expired  = (hold_cnt_q == HOLD_MAX);
    pick1    = req1 && (!req0 || rr_ptr_q);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rr_ptr_q   <= 1'b0;
      leds_q     <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            hold_cnt_q <= '0;
            busy_q     <= 1'b1;
            if (pick1) begin
              state_q  <= OWN1;
              gnt0_q   <= 1'b0;
              gnt1_q   <= 1'b1;
              leds_q   <= data1;
              rr_ptr_q <= 1'b0;
            end else begin
              state_q  <= OWN0;
              gnt0_q   <= 1'b1;
              gnt1_q   <= 1'b0;
              leds_q   <= data0;
              rr_ptr_q <= 1'b1;
            end
          end
        end
        OWN0, OWN1: begin
          if (expired && oth_req) begin
            // Direct handover: no IDLE cycle between the two grants.
            state_q    <= (state_q == OWN0) ? OWN1 : OWN0;
            gnt0_q     <= (state_q == OWN1);
            gnt1_q     <= (state_q == OWN0);
            leds_q     <= oth_data;
            hold_cnt_q <= '0;
            rr_ptr_q   <= (state_q == OWN1);
          end else if (expired && !own_req) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            if (!expired) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            if (own_req) begin
              leds_q <= own_data;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign leds        = leds_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios plus a randomized run checked
// against an ownership/age model of the arbitration rules.
module tb_led_bank_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, busy;
  logic [7:0] leds;
  logic [1:0] dbg_state;

  logic       h_req0, h_req1;
  logic [7:0] h_data0, h_data1;
  logic       h_gnt0, h_gnt1, h_busy;
  logic [7:0] h_leds;
  logic [1:0] h_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bank, for how many cycles, who is preferred.
  int         m_owner;
  int         m_age;
  int         m_pref;
  logic [7:0] m_leds;

  led_bank_arbiter #(.WIDTH(8), .HOLD_CYCLES(HOLD), .CNT_W(2)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .leds(leds), .busy(busy), .dbg_state_o(dbg_state)
  );

  led_bank_arbiter #(.WIDTH(8), .HOLD_CYCLES(1), .CNT_W(1)) dut_h1 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .req0(h_req0), .data0(h_data0), .req1(h_req1), .data1(h_data1),
    .gnt0(h_gnt0), .gnt1(h_gnt1), .leds(h_leds), .busy(h_busy), .dbg_state_o(h_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_pref  = 0;
    m_leds  = 8'h00;
  endtask

  task automatic model_step();
    int         x;
    logic       r[2];
    logic [7:0] d[2];
    r[0] = req0;  r[1] = req1;
    d[0] = data0; d[1] = data1;
    if (m_owner < 0) begin
      if (r[0] || r[1]) begin
        x = (r[0] && r[1]) ? m_pref : (r[0] ? 0 : 1);
        m_owner = x;
        m_age   = 0;
        m_leds  = d[x];
        m_pref  = 1 - x;
      end
    end else begin
      x = m_owner;
      if (m_age >= HOLD - 1 && r[1-x]) begin
        m_owner = 1 - x;
        m_age   = 0;
        m_leds  = d[1-x];
        m_pref  = x;
      end else if (m_age >= HOLD - 1 && !r[x]) begin
        m_owner = -1;
      end else begin
        m_age++;
        if (r[x]) m_leds = d[x];
      end
    end
  endtask

  function automatic logic [10:0] exp_vec();
    return {m_owner == 0, m_owner == 1, m_owner >= 0, m_leds};
  endfunction

  // Advance one clock: model consumes the inputs seen at the edge, bench
  // resumes on the following falling edge where outputs are stable.
  task automatic step();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    h_req0 = 1'b0; h_req1 = 1'b0; h_data0 = 8'h00; h_data1 = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req0 = 1'b1; data0 = 8'hFF; req1 = 1'b1; data1 = 8'hEE;
    model_reset();
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, busy, leds} !== 11'd0) begin
      n_err++; $display("FAIL reset_main got %b want %b", {gnt0, gnt1, busy, leds}, 11'd0);
    end
    n_vec++;
    if ({h_gnt0, h_gnt1, h_busy, h_leds} !== 11'd0) begin
      n_err++; $display("FAIL reset_h1 got %b want %b", {h_gnt0, h_gnt1, h_busy, h_leds}, 11'd0);
    end
    step();
    n_vec++;
    if ({gnt0, gnt1, busy, leds} !== 11'd0) begin
      n_err++; $display("FAIL reset_held got %b want %b", {gnt0, gnt1, busy, leds}, 11'd0);
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    do_reset();
    req0 = 1'b1; data0 = 8'hA5;
    step();
    n_vec++;
    if ({gnt0, gnt1, busy, leds} !== {3'b101, 8'hA5}) begin
      n_err++; $display("FAIL t1_grant got %b want %b", {gnt0, gnt1, busy, leds}, {3'b101, 8'hA5});
    end
    data0 = 8'h3C;
    step();
    n_vec++;
    if (leds !== 8'h3C) begin
      n_err++; $display("FAIL t1_data got %h want %h", leds, 8'h3C);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    step();
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL t2_first got %b want %b", {gnt0, gnt1}, 2'b10);
    end
    for (int i = 0; i < HOLD - 1; i++) begin
      step();
      n_vec++;
      if ({gnt0, gnt1} !== 2'b10) begin
        n_err++; $display("FAIL t2_hold0 cyc %0d got %b want %b", i, {gnt0, gnt1}, 2'b10);
      end
    end
    step();
    n_vec++;
    if ({gnt0, gnt1, leds} !== {2'b01, 8'h22}) begin
      n_err++; $display("FAIL t2_swap1 got %b want %b", {gnt0, gnt1, leds}, {2'b01, 8'h22});
    end
    for (int i = 0; i < HOLD - 1; i++) begin
      step();
      n_vec++;
      if ({gnt0, gnt1} !== 2'b01) begin
        n_err++; $display("FAIL t2_hold1 cyc %0d got %b want %b", i, {gnt0, gnt1}, 2'b01);
      end
    end
    step();
    n_vec++;
    if ({gnt0, gnt1, leds} !== {2'b10, 8'h11}) begin
      n_err++; $display("FAIL t2_swap0 got %b want %b", {gnt0, gnt1, leds}, {2'b10, 8'h11});
    end
  endtask

  task automatic test_drop_release();
    do_reset();
    req0 = 1'b1; data0 = 8'h5A;
    step();
    req0 = 1'b0; data0 = 8'hFF;
    for (int i = 0; i < HOLD - 1; i++) begin
      step();
      n_vec++;
      if ({gnt0, busy, leds} !== {2'b11, 8'h5A}) begin
        n_err++; $display("FAIL t3_frozen cyc %0d got %b want %b", i, {gnt0, busy, leds}, {2'b11, 8'h5A});
      end
    end
    step();
    n_vec++;
    if ({gnt0, gnt1, busy, leds} !== {3'b000, 8'h5A}) begin
      n_err++; $display("FAIL t3_idle got %b want %b", {gnt0, gnt1, busy, leds}, {3'b000, 8'h5A});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0 = 1'b1; data0 = 8'h01; data1 = 8'h02;
    step();
    req1 = 1'b1;
    step();
    req0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if ({gnt0, gnt1} !== 2'b10) begin
        n_err++; $display("FAIL t4_hold cyc %0d got %b want %b", i, {gnt0, gnt1}, 2'b10);
      end
    end
    step();
    n_vec++;
    if ({gnt0, gnt1, busy, leds} !== {3'b011, 8'h02}) begin
      n_err++; $display("FAIL t4_handover got %b want %b", {gnt0, gnt1, busy, leds}, {3'b011, 8'h02});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req1 = 1'b1; data1 = 8'hC3;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt1, busy, leds} !== 10'd0) begin
      n_err++; $display("FAIL t5_abort got %b want %b", {gnt1, busy, leds}, 10'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_vec++;
    if ({gnt0, gnt1, busy, leds} !== {3'b011, 8'hC3}) begin
      n_err++; $display("FAIL t5_regrant got %b want %b", {gnt0, gnt1, busy, leds}, {3'b011, 8'hC3});
    end
  endtask

  task automatic test_hold_one();
    logic       e0;
    logic [7:0] el;
    do_reset();
    h_req0 = 1'b1; h_req1 = 1'b1; h_data0 = 8'h0F; h_data1 = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      step();
      e0 = (i % 2 == 0);
      el = e0 ? 8'h0F : 8'hF0;
      n_vec++;
      if ({h_gnt0, h_gnt1, h_busy, h_leds} !== {e0, ~e0, 1'b1, el}) begin
        n_err++; $display("FAIL t6_alt cyc %0d got %b want %b", i, {h_gnt0, h_gnt1, h_busy, h_leds}, {e0, ~e0, 1'b1, el});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      data0 = 8'($urandom_range(0, 255));
      data1 = 8'($urandom_range(0, 255));
      step();
      n_vec++;
      if ({gnt0, gnt1, busy, leds} !== exp_vec()) begin
        n_err++; $display("FAIL rand cyc %0d got %b want %b", i, {gnt0, gnt1, busy, leds}, exp_vec());
      end
      n_vec++;
      if ((gnt0 & gnt1) !== 1'b0) begin
        n_err++; $display("FAIL rand_excl cyc %0d got %b want %b", i, gnt0 & gnt1, 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_contention();
    test_drop_release();
    test_back_to_back();
    test_async_reset();
    test_hold_one();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
